// File: rtl/fx_pkg.sv
// -----------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the fixed-point issue path.
//   - functional unit codes as produced by dispatch (FX-bound ops use FXUnitCode)
//   - instruction format codes
//   - default GPR address width
//   - bit offsets of the fields packed into the opaque instruction payload
//   - src_hit(): one scoreboard lookup term (operand used and register busy)
// No ports.
// -----------------------------------------------------------------------------
package fx_pkg;

   localparam int FX_REG_W = 5;

   typedef enum logic [2:0] {
      FXUnitCode   = 3'd0,
      FPUnitCode   = 3'd1,
      LSUnitCode   = 3'd2,
      BRUnitCode   = 3'd3,
      CRUnitCode   = 3'd4,
      SPRUnitCode  = 3'd5,
      TrapUnitCode = 3'd6
   } fx_unit_e;

   typedef enum logic [4:0] {
      FmtA       = 5'd0,
      FmtB       = 5'd1,
      FmtD       = 5'd2,
      FmtDS      = 5'd3,
      FmtDQ      = 5'd4,
      FmtI       = 5'd5,
      FmtM       = 5'd6,
      FmtMD      = 5'd7,
      FmtMDS     = 5'd8,
      FmtSC      = 5'd9,
      FmtVA      = 5'd10,
      FmtVX      = 5'd11,
      FmtX       = 5'd12,
      FmtXFL     = 5'd13,
      FmtXFX     = 5'd14,
      FmtXL      = 5'd15,
      FmtXO      = 5'd16,
      FmtXS      = 5'd17,
      FmtZ22     = 5'd18,
      FmtZ23     = 5'd19,
      FmtINVALID = 5'd31
   } fx_format_e;

   // Payload layout (the scheduler itself never looks inside the payload)
   localparam int PL_OPCODE_LSB  = 0;
   localparam int PL_OPCODE_W    = 6;
   localparam int PL_XOPCODE_LSB = 6;
   localparam int PL_XOPCODE_W   = 10;
   localparam int PL_FORMAT_LSB  = 16;
   localparam int PL_FORMAT_W    = 5;
   localparam int PL_IMM_LSB     = 21;
   localparam int PL_IMM_W       = 64;
   localparam int PL_OPND_LSB    = 85;
   localparam int PL_OPND_W      = 43;

   function automatic logic src_hit(input logic used, input logic busy);
      return used & busy;
   endfunction

endpackage

// File: rtl/fx_scoreboard.sv
// -----------------------------------------------------------------------------
// fx_scoreboard
// One busy bit per GPR. A bit is set when an op writing that GPR issues and
// cleared by the FX unit writeback. Set wins over clear in the same cycle
// because the newly issued op is the register's current producer.
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset (clears all)
//   set_i / setAddr_i         mark setAddr_i busy
//   clr_i / clrAddr_i         writeback: mark clrAddr_i free
//   src1Used_i/src1Addr_i     first source lookup
//   src2Used_i/src2Addr_i     second source lookup
//   dstWrite_i/dstAddr_i      destination lookup (WAW)
//   hazard_o                  any looked-up register is busy (combinational)
// -----------------------------------------------------------------------------
module fx_scoreboard
   import fx_pkg::*;
#(
   parameter int REG_W = FX_REG_W
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             set_i,
   input  logic [REG_W-1:0] setAddr_i,
   input  logic             clr_i,
   input  logic [REG_W-1:0] clrAddr_i,
   input  logic             src1Used_i,
   input  logic [REG_W-1:0] src1Addr_i,
   input  logic             src2Used_i,
   input  logic [REG_W-1:0] src2Addr_i,
   input  logic             dstWrite_i,
   input  logic [REG_W-1:0] dstAddr_i,
   output logic             hazard_o
);

   localparam int NREG = 2 ** REG_W;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Next busy vector: clear on writeback first, then OR in the issue set
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         busy_d[i] = (busy_q[i] & ~(clr_i & (clrAddr_i == REG_W'(i))))
                   | (set_i & (setAddr_i == REG_W'(i)));
      end
   end

   // Busy vector register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         busy_q <= {NREG{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // RAW on either source plus WAW on the destination
   always_comb begin
      hazard_o = src_hit(src1Used_i, busy_q[src1Addr_i])
               | src_hit(src2Used_i, busy_q[src2Addr_i])
               | src_hit(dstWrite_i, busy_q[dstAddr_i]);
   end

endmodule

// File: rtl/fx_issue_scheduler.sv
// -----------------------------------------------------------------------------
// fx_issue_scheduler
// In-order issue queue in front of the fixed-point unit. Dispatch enqueues
// FX-bound ops; the head issues once none of its registers has a write in
// flight (tracked by fx_scoreboard). Issue outputs are registered, so an op
// accepted at one edge can issue at the following edge at the earliest.
// Ports:
//   clock_i, reset_i       clock, synchronous active-high reset
//   enable_i               0 freezes issue (enqueue still allowed)
//   flush_i                drop all queued ops and any same-cycle enqueue
//   valid_i / ready_o      dispatch handshake (ready_o = !full & !reset_i)
//   payload_i, dstAddr_i, dstWrite_i, src1/2Addr_i, src1/2Used_i  op fields
//   issueValid_o           one-cycle pulse per issued op (FX unit enable)
//   issuePayload_o, issueDstAddr_o   registered fields of the issued op
//   wbValid_i / wbAddr_i   FX unit writeback, frees a busy register
//   stallCount_o, issueCount_o       saturating perf counters, present only
//                          when the macro FX_ISSUE_PERF_EN is defined
// -----------------------------------------------------------------------------
module fx_issue_scheduler
   import fx_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int REG_W     = FX_REG_W,
   parameter int PAYLOAD_W = 128
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 enable_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [PAYLOAD_W-1:0] payload_i,
   input  logic [REG_W-1:0]     dstAddr_i,
   input  logic                 dstWrite_i,
   input  logic [REG_W-1:0]     src1Addr_i,
   input  logic [REG_W-1:0]     src2Addr_i,
   input  logic                 src1Used_i,
   input  logic                 src2Used_i,
   output logic                 issueValid_o,
   output logic [PAYLOAD_W-1:0] issuePayload_o,
   output logic [REG_W-1:0]     issueDstAddr_o,
`ifdef FX_ISSUE_PERF_EN
   output logic [31:0]          stallCount_o,
   output logic [31:0]          issueCount_o,
`endif
   input  logic                 wbValid_i,
   input  logic [REG_W-1:0]     wbAddr_i
);

   // DEPTH is a power of two, so pointers wrap by plain overflow
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   // Queue storage (data only, no reset needed: validity comes from count)
   logic [PAYLOAD_W-1:0] qPayload_q [DEPTH];
   logic [REG_W-1:0]     qDst_q     [DEPTH];
   logic                 qDstWr_q   [DEPTH];
   logic [REG_W-1:0]     qSrc1_q    [DEPTH];
   logic                 qSrc1Use_q [DEPTH];
   logic [REG_W-1:0]     qSrc2_q    [DEPTH];
   logic                 qSrc2Use_q [DEPTH];

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 issueValid_q;
   logic [PAYLOAD_W-1:0] issuePayload_q;
   logic [REG_W-1:0]     issueDstAddr_q;

   logic full_s, empty_s, ready_s, accept_s, issue_s, hazard_s;

   fx_scoreboard #(
      .REG_W (REG_W)
   ) u_scoreboard (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .set_i      (issue_s & qDstWr_q[head_q]),
      .setAddr_i  (qDst_q[head_q]),
      .clr_i      (wbValid_i),
      .clrAddr_i  (wbAddr_i),
      .src1Used_i (qSrc1Use_q[head_q]),
      .src1Addr_i (qSrc1_q[head_q]),
      .src2Used_i (qSrc2Use_q[head_q]),
      .src2Addr_i (qSrc2_q[head_q]),
      .dstWrite_i (qDstWr_q[head_q]),
      .dstAddr_i  (qDst_q[head_q]),
      .hazard_o   (hazard_s)
   );

   // Handshake and issue decision; the head entry is only meaningful when not empty
   always_comb begin
      full_s   = (count_q == CNT_MAX);
      empty_s  = (count_q == {CNT_W{1'b0}});
      ready_s  = ~full_s & ~reset_i;
      accept_s = valid_i & ready_s & ~flush_i;
      issue_s  = ~empty_s & enable_i & ~hazard_s & ~flush_i;
   end

   // Pointer and occupancy next state; flush empties the queue by snapping head to tail
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = tail_q;
         count_d = {CNT_W{1'b0}};
      end else begin
         head_d = issue_s  ? (head_q + PTR_ONE) : head_q;
         tail_d = accept_s ? (tail_q + PTR_ONE) : tail_q;
         case ({accept_s, issue_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointers, count and the registered issue stage
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head_q         <= {PTR_W{1'b0}};
         tail_q         <= {PTR_W{1'b0}};
         count_q        <= {CNT_W{1'b0}};
         issueValid_q   <= 1'b0;
         issuePayload_q <= {PAYLOAD_W{1'b0}};
         issueDstAddr_q <= {REG_W{1'b0}};
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         issueValid_q <= issue_s;
         if (issue_s) begin
            issuePayload_q <= qPayload_q[head_q];
            issueDstAddr_q <= qDst_q[head_q];
         end
      end
   end

   // Write the accepted op at the tail
   always_ff @(posedge clock_i) begin
      if (accept_s) begin
         qPayload_q[tail_q] <= payload_i;
         qDst_q[tail_q]     <= dstAddr_i;
         qDstWr_q[tail_q]   <= dstWrite_i;
         qSrc1_q[tail_q]    <= src1Addr_i;
         qSrc1Use_q[tail_q] <= src1Used_i;
         qSrc2_q[tail_q]    <= src2Addr_i;
         qSrc2Use_q[tail_q] <= src2Used_i;
      end
   end

   assign ready_o        = ready_s;
   assign issueValid_o   = issueValid_q;
   assign issuePayload_o = issuePayload_q;
   assign issueDstAddr_o = issueDstAddr_q;

`ifdef FX_ISSUE_PERF_EN
   logic [31:0] stallCount_q;
   logic [31:0] issueCount_q;
   logic        stall_s;

   // A stall cycle is a non-empty, enabled queue whose head is blocked
   always_comb begin
      stall_s = ~empty_s & enable_i & hazard_s;
   end

   // Saturating counters; only reset clears them, flush leaves them alone
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         stallCount_q <= 32'd0;
         issueCount_q <= 32'd0;
      end else begin
         if (stall_s && (stallCount_q != 32'hFFFF_FFFF)) begin
            stallCount_q <= stallCount_q + 32'd1;
         end
         if (issue_s && (issueCount_q != 32'hFFFF_FFFF)) begin
            issueCount_q <= issueCount_q + 32'd1;
         end
      end
   end

   assign stallCount_o = stallCount_q;
   assign issueCount_o = issueCount_q;
`endif

endmodule

// File: tb/tb_fx_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fx_issue_scheduler
// Directed scenarios followed by random traffic. A queue-of-ops model with a
// busy-register array predicts ready_o, the issue outputs and the busy vector
// every cycle; a few literal expectations pin the model in directed scenarios.
// -----------------------------------------------------------------------------
module tb_fx_issue_scheduler;

   localparam int DEPTH = 4;
   localparam int REG_W = 5;
   localparam int PW    = 128;

   logic           clock_i = 1'b0;
   logic           reset_i, enable_i, flush_i, valid_i, ready_o;
   logic [PW-1:0]  payload_i;
   logic [REG_W-1:0] dstAddr_i, src1Addr_i, src2Addr_i, wbAddr_i;
   logic           dstWrite_i, src1Used_i, src2Used_i, wbValid_i;
   logic           issueValid_o;
   logic [PW-1:0]  issuePayload_o;
   logic [REG_W-1:0] issueDstAddr_o;
`ifdef FX_ISSUE_PERF_EN
   logic [31:0]    stallCount_o, issueCount_o;
`endif

   fx_issue_scheduler #(.DEPTH(DEPTH), .REG_W(REG_W), .PAYLOAD_W(PW)) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .enable_i       (enable_i),
      .flush_i        (flush_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .payload_i      (payload_i),
      .dstAddr_i      (dstAddr_i),
      .dstWrite_i     (dstWrite_i),
      .src1Addr_i     (src1Addr_i),
      .src2Addr_i     (src2Addr_i),
      .src1Used_i     (src1Used_i),
      .src2Used_i     (src2Used_i),
      .issueValid_o   (issueValid_o),
      .issuePayload_o (issuePayload_o),
      .issueDstAddr_o (issueDstAddr_o),
`ifdef FX_ISSUE_PERF_EN
      .stallCount_o   (stallCount_o),
      .issueCount_o   (issueCount_o),
`endif
      .wbValid_i      (wbValid_i),
      .wbAddr_i       (wbAddr_i)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [PW-1:0]    pl;
      logic [REG_W-1:0] dst;
      logic             dw;
      logic [REG_W-1:0] s1;
      logic             u1;
      logic [REG_W-1:0] s2;
      logic             u2;
   } op_t;

   op_t              mq[$];
   logic [31:0]      m_busy;
   logic             m_valid;
   logic [PW-1:0]    m_pl;
   logic [REG_W-1:0] m_dst;
   logic [31:0]      m_stall, m_issue;
   int               checks = 0;
   int               errors = 0;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      valid_i = 1'b0; flush_i = 1'b0; wbValid_i = 1'b0; wbAddr_i = 5'd0;
      payload_i = '0; dstAddr_i = 5'd0; dstWrite_i = 1'b0;
      src1Addr_i = 5'd0; src1Used_i = 1'b0; src2Addr_i = 5'd0; src2Used_i = 1'b0;
   endtask

   task automatic drive_op(input logic [PW-1:0] pl, input logic [4:0] dst, input logic dw,
                           input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
      valid_i = 1'b1; payload_i = pl; dstAddr_i = dst; dstWrite_i = dw;
      src1Addr_i = s1; src1Used_i = u1; src2Addr_i = s2; src2Used_i = u2;
   endtask

   // One clock: check ready_o on the current inputs, advance the model, then compare after the edge
   task automatic step();
      logic exp_ready, hz, iss;
      op_t  e, n;
      #1;
      exp_ready = !reset_i && (mq.size() < DEPTH);
      check("ready_o", {127'd0, ready_o}, {127'd0, exp_ready});
      if (reset_i) begin
         mq.delete();
         m_busy = 32'd0; m_valid = 1'b0; m_pl = '0; m_dst = 5'd0;
         m_stall = 32'd0; m_issue = 32'd0;
      end else begin
         hz = 1'b0;
         if (mq.size() > 0)
            hz = (mq[0].u1 && m_busy[mq[0].s1]) || (mq[0].u2 && m_busy[mq[0].s2]) ||
                 (mq[0].dw && m_busy[mq[0].dst]);
         iss = (mq.size() > 0) && enable_i && !hz && !flush_i;
         if ((mq.size() > 0) && enable_i && hz && (m_stall != 32'hFFFF_FFFF)) m_stall++;
         if (iss && (m_issue != 32'hFFFF_FFFF)) m_issue++;
         if (wbValid_i) m_busy[wbAddr_i] = 1'b0;
         if (flush_i) begin
            mq.delete();
            m_valid = 1'b0;
         end else begin
            if (iss) begin
               e = mq.pop_front();
               m_valid = 1'b1; m_pl = e.pl; m_dst = e.dst;
               if (e.dw) m_busy[e.dst] = 1'b1;
            end else begin
               m_valid = 1'b0;
            end
            if (valid_i && exp_ready) begin
               n.pl = payload_i; n.dst = dstAddr_i; n.dw = dstWrite_i;
               n.s1 = src1Addr_i; n.u1 = src1Used_i; n.s2 = src2Addr_i; n.u2 = src2Used_i;
               mq.push_back(n);
            end
         end
      end
      @(posedge clock_i);
      #1;
      check("issueValid_o", {127'd0, issueValid_o}, {127'd0, m_valid});
      check("issuePayload_o", issuePayload_o, m_pl);
      check("issueDstAddr_o", {123'd0, issueDstAddr_o}, {123'd0, m_dst});
      check("busy", {96'd0, dut.u_scoreboard.busy_q}, {96'd0, m_busy});
`ifdef FX_ISSUE_PERF_EN
      check("stallCount_o", {96'd0, stallCount_o}, {96'd0, m_stall});
      check("issueCount_o", {96'd0, issueCount_o}, {96'd0, m_issue});
`endif
   endtask

   initial begin
      logic [31:0] st0;
      idle();
      enable_i = 1'b1;
      m_busy = 32'd0; m_valid = 1'b0; m_pl = '0; m_dst = 5'd0; m_stall = 32'd0; m_issue = 32'd0;

      // T1 reset for two cycles
      reset_i = 1'b1;
      step(); step();
      check("T1 valid in reset", {127'd0, issueValid_o}, {127'd0, 1'b0});
      reset_i = 1'b0;
      #1;
      check("T1 ready after reset", {127'd0, ready_o}, {127'd0, 1'b1});

      // T2 independent ops issue back to back
      drive_op(128'h33, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      check("T2 no pass-through", {127'd0, issueValid_o}, {127'd0, 1'b0});
      drive_op(128'h44, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      check("T2 first dst", {123'd0, issueDstAddr_o}, {123'd0, 5'd3});
      idle(); step();
      check("T2 second valid", {127'd0, issueValid_o}, {127'd0, 1'b1});
      check("T2 second dst", {123'd0, issueDstAddr_o}, {123'd0, 5'd4});
      wbValid_i = 1'b1; wbAddr_i = 5'd3; step();
      wbAddr_i = 5'd4; step();
      idle();

      // T3 RAW on r5
      st0 = m_stall;
      drive_op(128'hA, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      drive_op(128'hB, 5'd6, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0); step();
      idle(); step();
      check("T3 held", {127'd0, issueValid_o}, {127'd0, 1'b0});
      wbValid_i = 1'b1; wbAddr_i = 5'd5; step();
      check("T3 held at wb edge", {127'd0, issueValid_o}, {127'd0, 1'b0});
      idle(); step();
      check("T3 B issues", {127'd0, issueValid_o}, {127'd0, 1'b1});
      check("T3 B payload", issuePayload_o, 128'hB);
      check("T3 model stalls", {96'd0, m_stall - st0}, {96'd0, 32'd2});

      // T4 fill with issue frozen, then drain in order
      enable_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_op(128'(i + 16), 5'(10 + i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      end
      idle(); #1;
      check("T4 full", {127'd0, ready_o}, {127'd0, 1'b0});
      enable_i = 1'b1; step();
      check("T4 first issued", {123'd0, issueDstAddr_o}, {123'd0, 5'd10});
      #1;
      check("T4 ready after issue", {127'd0, ready_o}, {127'd0, 1'b1});
      step(); step(); step();
      check("T4 last issued", {123'd0, issueDstAddr_o}, {123'd0, 5'd13});
      wbValid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin wbAddr_i = 5'(10 + i); step(); end
      idle();

      // T5 set and clear of r7 on the same edge
      drive_op(128'h77, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      idle(); wbValid_i = 1'b1; wbAddr_i = 5'd7; step();
      check("T5 set wins", {127'd0, dut.u_scoreboard.busy_q[7]}, {127'd0, 1'b1});
      step();
      idle();

      // T6 flush with r9 in flight
      drive_op(128'h99, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      idle(); step();
      enable_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_op(128'(i + 32), 5'(20 + i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      end
      idle(); flush_i = 1'b1; valid_i = 1'b1; step();
      idle(); enable_i = 1'b1; #1;
      check("T6 ready", {127'd0, ready_o}, {127'd0, 1'b1});
      check("T6 busy9 kept", {127'd0, dut.u_scoreboard.busy_q[9]}, {127'd0, 1'b1});
      step();
      check("T6 nothing issues", {127'd0, issueValid_o}, {127'd0, 1'b0});
      wbValid_i = 1'b1; wbAddr_i = 5'd9; step();
      check("T6 busy9 freed", {127'd0, dut.u_scoreboard.busy_q[9]}, {127'd0, 1'b0});
      idle();

      // Random traffic over a small register range to provoke hazards
      for (int c = 0; c < 3000; c++) begin
         reset_i    = ($urandom_range(0, 199) == 0);
         flush_i    = ($urandom_range(0, 29) == 0);
         enable_i   = ($urandom_range(0, 9) < 8);
         valid_i    = ($urandom_range(0, 9) < 6);
         payload_i  = {$urandom, $urandom, $urandom, $urandom};
         dstAddr_i  = 5'($urandom_range(0, 7));
         dstWrite_i = ($urandom_range(0, 3) != 0);
         src1Addr_i = 5'($urandom_range(0, 7));
         src1Used_i = $urandom_range(0, 1);
         src2Addr_i = 5'($urandom_range(0, 7));
         src2Used_i = $urandom_range(0, 1);
         wbValid_i  = ($urandom_range(0, 9) < 5);
         wbAddr_i   = 5'($urandom_range(0, 7));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
